// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 8-digit multiplexed seven-segment driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; decimal point is not driven.
package seg7_pkg;

    typedef logic [4:0] char_t;
    typedef logic [6:0] seg_t;

    localparam int unsigned NUM_DIGITS = 8;

    localparam char_t CH_BLANK = 5'd16;
    localparam char_t CH_B     = 5'd17;
    localparam char_t CH_C     = 5'd18;
    localparam char_t CH_DASH  = 5'd19;

    localparam seg_t SEG_HEX_0 = 7'h40;
    localparam seg_t SEG_HEX_1 = 7'h79;
    localparam seg_t SEG_HEX_2 = 7'h24;
    localparam seg_t SEG_HEX_3 = 7'h30;
    localparam seg_t SEG_HEX_4 = 7'h19;
    localparam seg_t SEG_HEX_5 = 7'h12;
    localparam seg_t SEG_HEX_6 = 7'h02;
    localparam seg_t SEG_HEX_7 = 7'h78;
    localparam seg_t SEG_HEX_8 = 7'h00;
    localparam seg_t SEG_HEX_9 = 7'h10;
    localparam seg_t SEG_HEX_A = 7'h08;
    localparam seg_t SEG_HEX_B = 7'h03;
    localparam seg_t SEG_HEX_C = 7'h46;
    localparam seg_t SEG_HEX_D = 7'h21;
    localparam seg_t SEG_HEX_E = 7'h06;
    localparam seg_t SEG_HEX_F = 7'h0E;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_DASH  = 7'h3F;

    // One complete display image; chars[i] drives digit i, digit 0 rightmost.
    typedef struct packed {
        char_t [NUM_DIGITS-1:0] chars;
        logic  [NUM_DIGITS-1:0] blank;
        logic  [NUM_DIGITS-1:0] blink;
    } disp_t;

    localparam disp_t DISP_RESET = '{
        chars: {NUM_DIGITS{CH_BLANK}},
        blank: '0,
        blink: '0
    };

    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational char-code to segment lookup: 0-15 hex, 16 blank, 17 'b', 18 'C',
// 19 '-', 20-31 blank.
module seg7_char_decode
    import seg7_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:     seg = SEG_HEX_0;
            5'd1:     seg = SEG_HEX_1;
            5'd2:     seg = SEG_HEX_2;
            5'd3:     seg = SEG_HEX_3;
            5'd4:     seg = SEG_HEX_4;
            5'd5:     seg = SEG_HEX_5;
            5'd6:     seg = SEG_HEX_6;
            5'd7:     seg = SEG_HEX_7;
            5'd8:     seg = SEG_HEX_8;
            5'd9:     seg = SEG_HEX_9;
            5'd10:    seg = SEG_HEX_A;
            5'd11:    seg = SEG_HEX_B;
            5'd12:    seg = SEG_HEX_C;
            5'd13:    seg = SEG_HEX_D;
            5'd14:    seg = SEG_HEX_E;
            5'd15:    seg = SEG_HEX_F;
            CH_BLANK: seg = SEG_BLANK;
            CH_B:     seg = SEG_B;
            CH_C:     seg = SEG_C;
            CH_DASH:  seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment scan driver with frame-synchronous double-buffered
// loads. Optional digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned BLINK_HZ   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] chars,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [7:0]  an,
    output logic [6:0]  digit
);

    localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic          pending_q;
    disp_t         shadow_q;
    disp_t         active_q;
    disp_t         incoming;

    logic  presc_wrap;
    logic  boundary;
    logic  blink_phase;
    logic  dark;
    char_t cur_char;
    seg_t  cur_seg;

    assign incoming = '{chars: chars, blank: blank_mask, blink: blink_mask};

    assign presc_wrap = (presc_q == PW'(DIV - 1));
    assign boundary   = presc_wrap && (idx_q == 3'd7);

    assign cur_char = active_q.chars[idx_q];

    seg7_char_decode u_decode (
        .code (cur_char),
        .seg  (cur_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int unsigned BLINK_DIV = (CLK_HZ / (2 * BLINK_HZ) > 1) ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int unsigned BW        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = 1'b0;
`endif

    // A digit holding a blank glyph is treated as blanked so the anode stays off too.
    assign dark = active_q.blank[idx_q]
                | (active_q.blink[idx_q] & blink_phase)
                | (cur_seg == SEG_BLANK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            shadow_q   <= DISP_RESET;
            active_q   <= DISP_RESET;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            an         <= '1;
            digit      <= SEG_BLANK;
        end else begin
            if (presc_wrap) begin
                presc_q <= '0;
                idx_q   <= idx_q + 3'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            frame_tick <= boundary;
            load_ack   <= 1'b0;

            // A load landing on the boundary bypasses the shadow and supersedes any pending image.
            if (boundary && load) begin
                active_q  <= incoming;
                shadow_q  <= incoming;
                pending_q <= 1'b0;
                load_ack  <= 1'b1;
            end else if (boundary && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
                load_ack  <= 1'b1;
            end else if (load) begin
                shadow_q  <= incoming;
                pending_q <= 1'b1;
            end

            if (dark) begin
                an    <= '1;
                digit <= SEG_BLANK;
            end else begin
                an    <= anode_sel(idx_q);
                digit <= cur_seg;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at DIV=8 (64-cycle frame), blink half-period 16.
// Stimulus queues expected display/tick/ack events; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [39:0] chars = '0;
    logic [7:0]  blank_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic        load_ack;
    logic        frame_tick;
    logic [7:0]  an;
    logic [6:0]  digit;

    seg7_scan_driver #(
        .CLK_HZ     (800),
        .REFRESH_HZ (100),
        .BLINK_HZ   (25)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .chars      (chars),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .load_ack   (load_ack),
        .frame_tick (frame_tick),
        .an         (an),
        .digit      (digit)
    );

    always #5 clock = ~clock;

    typedef logic [7:0][14:0] frame_t;
    typedef struct {
        int          cyc;
        logic [14:0] ad;
    } disp_exp_t;

    localparam logic [14:0] DK = 15'h7FFF;

    localparam logic [39:0] C1234 = {5'd16, 5'd16, 5'd16, 5'd16, 5'd1, 5'd2, 5'd3, 5'd4};
    localparam logic [39:0] C5678 = {5'd16, 5'd16, 5'd16, 5'd16, 5'd5, 5'd6, 5'd7, 5'd8};
    localparam logic [39:0] CMIX  = {5'd15, 5'd0, 5'd31, 5'd20, 5'd19, 5'd17, 5'd18, 5'd8};

    frame_t t_dark, t_1234, t_5678, t_mix, t_blink;

    disp_exp_t disp_q[$];
    int        tick_q[$];
    int        ack_q[$];
    int        cyc;
    int        total = 0;
    int        bad = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected pulse at cyc %0d (t=%0t)", name, cyc, $time);
    endtask

    initial begin : monitor
        disp_exp_t e;
        forever begin
            @(posedge clock);
            #1;
            while (!reset && disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
                e = disp_q.pop_front();
                chk($sformatf("disp{an,digit}@%0d", e.cyc), {17'd0, an, digit}, {17'd0, e.ad});
            end
            if (frame_tick === 1'b1) begin
                if (tick_q.size() == 0) unexpected("frame_tick");
                else chk("frame_tick cyc", cyc, tick_q.pop_front());
            end
            if (load_ack === 1'b1) begin
                if (ack_q.size() == 0) unexpected("load_ack");
                else chk("load_ack cyc", cyc, ack_q.pop_front());
            end
        end
    end

    task automatic push_disp(input int from, input int to, input frame_t t);
        for (int c = from; c <= to; c++)
            disp_q.push_back('{c, t[((c - 1) / 8) % 8]});
    endtask

    task automatic push_ticks(input int n);
        for (int k = 1; k <= n; k++) tick_q.push_back(64 * k);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic do_load(input int at, input logic [39:0] ch, input logic [7:0] bm,
                           input logic [7:0] blm);
        wait_until(at);
        chars = ch;
        blank_mask = bm;
        blink_mask = blm;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic reset_begin(input string ph);
        reset = 1'b1;
        #1;
        chk({ph, " reset an"}, {24'd0, an}, 32'hFF);
        chk({ph, " reset digit"}, {25'd0, digit}, 32'h7F);
        chk({ph, " reset load_ack"}, {31'd0, load_ack}, 32'd0);
        chk({ph, " reset frame_tick"}, {31'd0, frame_tick}, 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_drained(input string ph);
        chk({ph, " display events left"}, disp_q.size(), 0);
        chk({ph, " frame_tick events left"}, tick_q.size(), 0);
        chk({ph, " load_ack events left"}, ack_q.size(), 0);
    endtask

    initial begin
        t_dark  = {8{DK}};
        t_1234  = {DK, DK, DK, DK, {8'hF7, 7'h79}, {8'hFB, 7'h24}, {8'hFD, 7'h30}, {8'hFE, 7'h19}};
        t_5678  = {DK, DK, DK, DK, {8'hF7, 7'h12}, {8'hFB, 7'h02}, {8'hFD, 7'h78}, {8'hFE, 7'h00}};
        t_mix   = {{8'h7F, 7'h0E}, {8'hBF, 7'h40}, DK, DK,
                   {8'hF7, 7'h3F}, DK, {8'hFD, 7'h46}, {8'hFE, 7'h00}};
`ifdef SEG7_BLINK_EN
        // Digit 2's scan slot always falls in the blink-off half-period; digit 0's never does.
        t_blink = {DK, DK, DK, DK, {8'hF7, 7'h79}, DK, {8'hFD, 7'h30}, {8'hFE, 7'h19}};
`else
        t_blink = t_1234;
`endif

        @(negedge clock);

        // Idle after reset: dark, ticks every 64 cycles.
        reset_begin("A");
        push_disp(1, 192, t_dark);
        push_ticks(3);
        release_reset();
        wait_until(195);
        check_drained("A");

        // Mid-frame load shows only from the next frame.
        reset_begin("B");
        push_disp(1, 64, t_dark);
        push_disp(65, 192, t_1234);
        push_ticks(3);
        ack_q.push_back(64);
        release_reset();
        do_load(20, C1234, 8'h00, 8'h00);
        wait_until(195);
        check_drained("B");

        // Two loads in one frame: last wins, single ack; then reset with a load pending.
        reset_begin("C");
        push_disp(1, 64, t_dark);
        push_disp(65, 133, t_5678);
        push_ticks(2);
        ack_q.push_back(64);
        release_reset();
        do_load(10, C1234, 8'h00, 8'h00);
        do_load(40, C5678, 8'h00, 8'h00);
        do_load(131, C1234, 8'h00, 8'h00);
        wait_until(133);
        reset_begin("D");
        check_drained("C");
        push_disp(1, 192, t_dark);
        push_ticks(3);
        release_reset();
        wait_until(195);
        check_drained("D");

        // Loads exactly on the boundary, one of them overriding a pending image.
        reset_begin("E");
        push_disp(1, 64, t_dark);
        push_disp(65, 128, t_mix);
        push_disp(129, 192, t_1234);
        push_ticks(3);
        ack_q.push_back(64);
        ack_q.push_back(128);
        release_reset();
        do_load(63, CMIX, 8'h04, 8'h00);
        do_load(100, C5678, 8'h00, 8'h00);
        do_load(127, C1234, 8'h00, 8'h00);
        wait_until(195);
        check_drained("E");

        // Blink mask on digits 0 and 2.
        reset_begin("F");
        push_disp(1, 64, t_dark);
        push_disp(65, 192, t_blink);
        push_ticks(3);
        ack_q.push_back(64);
        release_reset();
        do_load(5, C1234, 8'h00, 8'h05);
        wait_until(195);
        check_drained("F");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
